// File: rtl/ulpi_reg_sequencer.sv
// ULPI register-access sequencer: round-robin arbitration between requesters, then
// command/data strobes to the link, write completion or read-data capture with timeout.
module ulpi_reg_sequencer #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_we,
    input  logic [6*NREQ-1:0]    req_addr,
    input  logic [8*NREQ-1:0]    req_wdata,
    output logic [NREQ-1:0]      ack,
    output logic [7:0]           rdata,
    output logic                 rd_timeout,
    output logic [7:0]           link_cmd,
    output logic                 link_cmd_strobe,
    input  logic                 link_cmd_busy,
    input  logic [7:0]           link_data,
    input  logic                 link_data_valid
);
    localparam int IW = (NREQ > 2) ? 2 : 1;

    typedef enum logic [2:0] {
        IDLE, CMD, CMD_GAP, WDATA, WR_GAP, WR_WAIT, RD_WAIT
    } state_t;

    state_t        state_reg, state_next;
    logic [IW-1:0] last_grant_reg, grant_idx_reg, pick, cand;
    logic          pick_valid;
    logic          we_reg;
    logic [5:0]    addr_reg;
    logic [7:0]    wdata_reg, wait_cnt_reg, link_cmd_reg, rdata_reg;
    logic          rd_timeout_reg, rd_ack_reg;
    logic          grant, wr_done, rd_done, rd_expire, strobe;
    logic [7:0]    cmd_byte;

    // Round-robin search starting just above the previous winner.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        cand       = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IW'((int'(last_grant_reg) + i) % NREQ);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick       = cand;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        strobe     = 1'b0;
        cmd_byte   = link_cmd_reg;
        grant      = 1'b0;
        wr_done    = 1'b0;
        rd_done    = 1'b0;
        rd_expire  = 1'b0;
        case (state_reg)
            IDLE: begin
                // A registered read ack occupies the first IDLE cycle; no grant then.
                if (pick_valid && !rd_ack_reg) begin
                    grant      = 1'b1;
                    state_next = CMD;
                end
            end
            CMD: begin
                if (!link_cmd_busy) begin
                    strobe     = 1'b1;
                    cmd_byte   = {1'b1, ~we_reg, addr_reg};
                    state_next = CMD_GAP;
                end
            end
            CMD_GAP: state_next = we_reg ? WDATA : RD_WAIT;
            WDATA: begin
                if (!link_cmd_busy) begin
                    strobe     = 1'b1;
                    cmd_byte   = wdata_reg;
                    state_next = WR_GAP;
                end
            end
            WR_GAP: state_next = WR_WAIT;
            WR_WAIT: begin
                if (!link_cmd_busy) begin
                    wr_done    = 1'b1;
                    state_next = IDLE;
                end
            end
            RD_WAIT: begin
                if (link_data_valid) begin
                    rd_done    = 1'b1;
                    state_next = IDLE;
                end else if (wait_cnt_reg >= 8'(TIMEOUT)) begin
                    rd_expire  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= IW'(NREQ - 1);
            grant_idx_reg  <= '0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            wait_cnt_reg   <= '0;
            link_cmd_reg   <= '0;
            rdata_reg      <= '0;
            rd_timeout_reg <= 1'b0;
            rd_ack_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rd_ack_reg <= rd_done | rd_expire;
            if (strobe)
                link_cmd_reg <= cmd_byte;
            if (grant) begin
                grant_idx_reg  <= pick;
                last_grant_reg <= pick;
                we_reg         <= req_we[pick];
                addr_reg       <= req_addr[6*32'(pick) +: 6];
                wdata_reg      <= req_wdata[8*32'(pick) +: 8];
            end
            if (state_reg == CMD_GAP)
                wait_cnt_reg <= '0;
            else if (state_reg == RD_WAIT && !link_data_valid)
                wait_cnt_reg <= wait_cnt_reg + 8'd1;
            if (rd_done) begin
                rdata_reg      <= link_data;
                rd_timeout_reg <= 1'b0;
            end else if (rd_expire) begin
                rdata_reg      <= 8'h00;
                rd_timeout_reg <= 1'b1;
            end
        end
    end

    // Write acks are issued in WR_WAIT itself; read acks follow the captured data.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ack
            assign ack[gi] = (wr_done | rd_ack_reg) && (grant_idx_reg == IW'(gi));
        end
    endgenerate

    assign link_cmd_strobe = strobe;
    assign link_cmd        = cmd_byte;
    assign rdata           = rdata_reg;
    assign rd_timeout      = rd_timeout_reg;

endmodule

// File: tb/tb_ulpi_reg_sequencer.sv
// Bench for ulpi_reg_sequencer: directed and randomized transactions checked against
// a transaction-level timeline model (grant order, strobe cycles, ack cycle, read result).
module tb_ulpi_reg_sequencer;
    localparam int N  = 3;
    localparam int TO = 10;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req, req_we;
    logic [6*N-1:0]   req_addr;
    logic [8*N-1:0]   req_wdata;
    logic [N-1:0]     ack;
    logic [7:0]       rdata;
    logic             rd_timeout;
    logic [7:0]       link_cmd;
    logic             link_cmd_strobe;
    logic             link_cmd_busy;
    logic [7:0]       link_data;
    logic             link_data_valid;

    ulpi_reg_sequencer #(.NREQ(N), .TIMEOUT(TO)) dut (
        .clk             (clk),
        .reset           (reset),
        .req             (req),
        .req_we          (req_we),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .ack             (ack),
        .rdata           (rdata),
        .rd_timeout      (rd_timeout),
        .link_cmd        (link_cmd),
        .link_cmd_strobe (link_cmd_strobe),
        .link_cmd_busy   (link_cmd_busy),
        .link_data       (link_data),
        .link_data_valid (link_data_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_txn    = 0;

    // Requester-side model state
    logic [N-1:0] held;
    logic         m_we    [N];
    logic [5:0]   m_addr  [N];
    logic [7:0]   m_wdata [N];
    int           m_last;
    logic [7:0]   m_cmd;
    logic [7:0]   m_rdata;
    logic         m_to;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic drive_req();
        req = held;
        for (int i = 0; i < N; i++) begin
            req_we[i]           = m_we[i];
            req_addr[6*i +: 6]  = m_addr[i];
            req_wdata[8*i +: 8] = m_wdata[i];
        end
    endtask

    task automatic new_req(input int i);
        held[i]    = 1'b1;
        m_we[i]    = 1'($urandom_range(0, 1));
        m_addr[i]  = 6'($urandom);
        m_wdata[i] = 8'($urandom);
    endtask

    // One access from grant to ack. Cycle 0 is the grant cycle; b1/b2/b3 are busy
    // lengths in CMD/WDATA/WR_WAIT; d is the read-data delay after RD_WAIT entry
    // (d > TO means no data); abort >= 0 asserts reset at that cycle instead.
    task automatic run_txn(input int b1, input int b2, input int b3, input int d,
                           input int rdv, input bit junk, input bit drop, input int abort);
        int         w, s1, s2, e, ackc;
        bit         we_w, exp_strobe, bsy;
        logic [7:0] cmd1, cmd2, rd_byte, exp_cmd;
        bit         aborted;
        w = -1;
        aborted = 1'b0;
        if (held == '0)
            new_req($urandom_range(0, N-1));
        for (int i = 1; i <= N; i++)
            if (w < 0 && held[(m_last + i) % N]) w = (m_last + i) % N;
        we_w    = m_we[w];
        cmd1    = {1'b1, ~we_w, m_addr[w]};
        cmd2    = m_wdata[w];
        rd_byte = (rdv < 0) ? 8'($urandom) : 8'(rdv);
        s1 = 1 + b1;
        s2 = s1 + 2 + b2;
        e  = s1 + 2;
        if (we_w)         ackc = s2 + 2 + b3;
        else if (d <= TO) ackc = e + d + 1;
        else              ackc = e + TO + 1;
        for (int c = 0; c <= ackc; c++) begin
            @(negedge clk);
            if (c == 1) begin
                // Scramble the winner's inputs after grant; the access must not change.
                m_we[w]    = 1'($urandom_range(0, 1));
                m_addr[w]  = 6'($urandom);
                m_wdata[w] = 8'($urandom);
            end
            drive_req();
            bsy = 1'b0;
            if (c >= 1 && c < s1) bsy = 1'b1;
            if (we_w && c >= s1 + 2 && c < s2) bsy = 1'b1;
            if (we_w && c >= s2 + 2 && c < ackc) bsy = 1'b1;
            if (c == 0 || c == s1 + 1 || (we_w && c == s2 + 1) || (!we_w && c >= e))
                bsy = 1'($urandom_range(0, 1));
            link_cmd_busy   = bsy;
            link_data_valid = 1'b0;
            link_data       = 8'($urandom);
            if (!we_w && d <= TO && c == e + d) begin
                link_data_valid = 1'b1;
                link_data       = rd_byte;
            end
            if (junk && (c == 1 || c == ackc))
                link_data_valid = 1'b1;
            if (c == abort) begin
                reset = 1'b1;
                req   = '0;
                #1;
                check("rst_ack", ack, 0);
                check("rst_strobe", link_cmd_strobe, 0);
                check("rst_link_cmd", link_cmd, 0);
                check("rst_rdata", rdata, 0);
                check("rst_timeout", rd_timeout, 0);
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    link_data_valid = 1'b1;
                    #1;
                    check("rst_hold_ack", ack, 0);
                    check("rst_hold_strobe", link_cmd_strobe, 0);
                end
                @(negedge clk);
                reset           = 1'b0;
                link_data_valid = 1'b0;
                #1;
                check("post_rst_ack", ack, 0);
                m_last  = N - 1;
                m_cmd   = 8'h00;
                m_rdata = 8'h00;
                m_to    = 1'b0;
                aborted = 1'b1;
                break;
            end
            #1;
            exp_strobe = (c == s1) || (we_w && c == s2);
            exp_cmd    = (c == s1) ? cmd1 : ((we_w && c == s2) ? cmd2 : m_cmd);
            if (c == ackc && !we_w) begin
                m_rdata = (d <= TO) ? rd_byte : 8'h00;
                m_to    = (d > TO);
            end
            check("strobe", link_cmd_strobe, exp_strobe);
            check("link_cmd", link_cmd, exp_cmd);
            check("ack", ack, (c == ackc) ? (32'd1 << w) : 32'd0);
            check("rdata", rdata, m_rdata);
            check("rd_timeout", rd_timeout, m_to);
            m_cmd = exp_cmd;
        end
        if (!aborted) begin
            m_last = w;
            if (drop) held[w] = 1'b0;
        end
        n_txn++;
        $display("txn %0d: grant=%0d %s cmd=%h data=%h b=%0d/%0d/%0d d=%0d ack_cycle=%0d%s",
                 n_txn, w, we_w ? "WR" : "RD", cmd1, we_w ? cmd2 : m_rdata,
                 b1, b2, b3, d, ackc, aborted ? " aborted by reset" : "");
    endtask

    initial begin
        reset           = 1'b1;
        held            = '0;
        link_cmd_busy   = 1'b0;
        link_data_valid = 1'b0;
        link_data       = 8'h00;
        for (int i = 0; i < N; i++) begin
            m_we[i] = 1'b0; m_addr[i] = '0; m_wdata[i] = '0;
        end
        drive_req();
        m_last  = N - 1;
        m_cmd   = 8'h00;
        m_rdata = 8'h00;
        m_to    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_ack", ack, 0);
        check("reset_strobe", link_cmd_strobe, 0);
        check("reset_link_cmd", link_cmd, 0);
        check("reset_rdata", rdata, 0);
        check("reset_timeout", rd_timeout, 0);
        @(negedge clk);
        reset = 1'b0;

        // Basic write, requester 0
        held[0] = 1'b1; m_we[0] = 1'b1; m_addr[0] = 6'h0A; m_wdata[0] = 8'h5C;
        run_txn(0, 0, 0, 0, -1, 0, 1, -1);
        // Basic read, requester 1, data 4 cycles after strobe
        held[1] = 1'b1; m_we[1] = 1'b0; m_addr[1] = 6'h15;
        run_txn(0, 0, 0, 2, 8'h3E, 1, 1, -1);
        // Read timeout, then the boundary delays
        held[2] = 1'b1; m_we[2] = 1'b0;
        run_txn(0, 0, 0, 99, -1, 1, 1, -1);
        held[0] = 1'b1; m_we[0] = 1'b0;
        run_txn(1, 0, 0, TO, -1, 0, 1, -1);
        held[1] = 1'b1; m_we[1] = 1'b0;
        run_txn(0, 0, 0, 0, -1, 0, 1, -1);
        // Fairness: requesters 0 and 1 held continuously
        held = '0; held[0] = 1'b1; held[1] = 1'b1;
        for (int k = 0; k < 4; k++)
            run_txn(0, 0, 0, 1, -1, 0, 0, -1);
        // Backpressure on CMD, WDATA and WR_WAIT
        held = '0; held[2] = 1'b1; m_we[2] = 1'b1;
        run_txn(5, 5, 5, 0, -1, 0, 1, -1);
        // Reset in the middle of a read, then a normal access
        held = '0; held[1] = 1'b1; m_we[1] = 1'b0;
        run_txn(0, 0, 0, 99, -1, 0, 0, 6);
        m_we[1] = 1'b0;
        run_txn(0, 0, 0, 3, -1, 0, 1, -1);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < N; i++)
                if (!held[i] && $urandom_range(0, 9) < 3) new_req(i);
            run_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, TO + 3), -1, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
